// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS
// datapath. Drives the datapath mux selects and write strobes, handshakes
// with instruction/data memories, and counts retired instructions.
module mc_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        irwe,
    output logic        pcwe,
    output logic        rfwe,
    output logic        dmem_req,
    output logic        dmwe,
    output logic [4:0]  npcop,
    output logic [1:0]  wrsel,
    output logic [1:0]  wdsel,
    output logic [1:0]  extop,
    output logic [1:0]  asel,
    output logic [1:0]  bsel,
    output logic [4:0]  aluop,
    output logic [1:0]  dmtype,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        instr_done,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Instruction class: selects the state path taken after DECODE.
    typedef enum logic [2:0] {
        K_NOP,
        K_ALU,
        K_LOAD,
        K_STORE,
        K_BRANCH,
        K_JUMP,
        K_LINK,
        K_ILLEGAL
    } kind_t;

    state_t      cur, nxt;
    kind_t       kind;
    logic [31:0] ir;
    logic [5:0]  op, funct;
    logic        last;

    logic [4:0]  d_npcop, d_aluop;
    logic [1:0]  d_wrsel, d_wdsel, d_extop, d_asel, d_bsel, d_dmtype;

    assign op    = ir[31:26];
    assign funct = ir[5:0];

    // Decode IR into instruction class and datapath mux fields.
    always_comb begin
        kind     = K_ILLEGAL;
        d_npcop  = '0;
        d_aluop  = '0;
        d_wrsel  = '0;
        d_wdsel  = '0;
        d_extop  = '0;
        d_asel   = '0;
        d_bsel   = '0;
        d_dmtype = '0;
        if (ir == '0) begin
            kind = K_NOP;
        end else if (op == 6'h00) begin
            case (funct)
                6'h21: begin kind = K_ALU; d_wrsel = 2'd1; end
                6'h23: begin kind = K_ALU; d_wrsel = 2'd1; d_aluop = 5'd1; end
                6'h00: begin kind = K_ALU; d_wrsel = 2'd1; d_asel = 2'd1; d_aluop = 5'd5; end
                6'h2A: begin kind = K_ALU; d_wrsel = 2'd1; d_aluop = 5'd6; end
                6'h08: begin kind = K_BRANCH; d_npcop = 5'd3; d_aluop = 5'd4; end
                6'h09: begin kind = K_LINK; d_npcop = 5'd3; d_wrsel = 2'd1; d_wdsel = 2'd2; end
                default: kind = K_ILLEGAL;
            endcase
        end else begin
            case (op)
                6'h0D: begin kind = K_ALU; d_bsel = 2'd1; d_aluop = 5'd2; end
                6'h0F: begin kind = K_ALU; d_bsel = 2'd1; d_aluop = 5'd3; end
                6'h23: begin kind = K_LOAD; d_extop = 2'd1; d_bsel = 2'd1; d_wdsel = 2'd1; end
                6'h20: begin kind = K_LOAD; d_extop = 2'd1; d_bsel = 2'd1; d_wdsel = 2'd1; d_dmtype = 2'd2; end
                6'h2B: begin kind = K_STORE; d_extop = 2'd1; d_bsel = 2'd1; end
                6'h29: begin kind = K_STORE; d_extop = 2'd1; d_bsel = 2'd1; d_dmtype = 2'd1; end
                6'h04: begin kind = K_BRANCH; d_npcop = 5'd1; d_extop = 2'd1; d_aluop = 5'd1; end
                6'h07: begin kind = K_BRANCH; d_npcop = 5'd4; d_extop = 2'd1; end
                6'h02: begin kind = K_JUMP; d_npcop = 5'd2; end
                6'h03: begin kind = K_LINK; d_npcop = 5'd2; d_wrsel = 2'd2; d_wdsel = 2'd2; end
                default: kind = K_ILLEGAL;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= S_FETCH;
        else          cur <= nxt;
    end

    // Next-state logic; 'last' marks the final cycle of an instruction.
    always_comb begin
        nxt  = cur;
        last = 1'b0;
        case (cur)
            S_FETCH: begin
                if (imem_ack) nxt = S_DECODE;
            end
            S_DECODE: begin
                case (kind)
                    K_NOP, K_JUMP, K_ILLEGAL: last = 1'b1;
                    K_LINK:                   nxt  = S_WB;
                    default:                  nxt  = S_EXE;
                endcase
            end
            S_EXE: begin
                case (kind)
                    K_BRANCH:        last = 1'b1;
                    K_LOAD, K_STORE: nxt  = S_MEM;
                    default:         nxt  = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (kind == K_STORE) last = 1'b1;
                    else                 nxt  = S_WB;
                end
            end
            S_WB: begin
                last = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
        if (last) nxt = S_FETCH;
    end

    // Instruction register, loaded on an acknowledged fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       ir <= '0;
        else if (cur == S_FETCH && imem_ack) ir <= instr;
    end

    // Retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  instret <= '0;
        else if (last) instret <= instret + 32'd1;
    end

    // Strobes and mux fields; fields are forced to zero while fetching.
    always_comb begin
        imem_req   = reset_n && (cur == S_FETCH);
        irwe       = reset_n && (cur == S_FETCH) && imem_ack;
        pcwe       = last;
        instr_done = last;
        rfwe       = (cur == S_WB);
        dmem_req   = (cur == S_MEM);
        dmwe       = (cur == S_MEM) && (kind == K_STORE);
        illegal    = (cur == S_DECODE) && (kind == K_ILLEGAL);
        state      = cur;
        npcop      = '0;
        aluop      = '0;
        wrsel      = '0;
        wdsel      = '0;
        extop      = '0;
        asel       = '0;
        bsel       = '0;
        dmtype     = '0;
        if (cur != S_FETCH) begin
            npcop  = d_npcop;
            aluop  = d_aluop;
            wrsel  = d_wrsel;
            wdsel  = d_wdsel;
            extop  = d_extop;
            asel   = d_asel;
            bsel   = d_bsel;
            dmtype = d_dmtype;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller with hand-computed expectations.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack;
    logic        imem_req, irwe, pcwe, rfwe, dmem_req, dmwe;
    logic [4:0]  npcop, aluop;
    logic [1:0]  wrsel, wdsel, extop, asel, bsel, dmtype;
    logic [2:0]  state;
    logic        illegal, instr_done;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .irwe       (irwe),
        .pcwe       (pcwe),
        .rfwe       (rfwe),
        .dmem_req   (dmem_req),
        .dmwe       (dmwe),
        .npcop      (npcop),
        .wrsel      (wrsel),
        .wdsel      (wdsel),
        .extop      (extop),
        .asel       (asel),
        .bsel       (bsel),
        .aluop      (aluop),
        .dmtype     (dmtype),
        .state      (state),
        .illegal    (illegal),
        .instr_done (instr_done),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply acks for the new cycle and let outputs settle.
    task automatic cyc(input logic ia, input logic da);
        @(posedge clk);
        #1;
        imem_ack = ia;
        dmem_ack = da;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        instr    = 32'h0000_0000;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // reset held with imem_ack=1
        chk("rst_imem_req", imem_req, 0);
        chk("rst_irwe", irwe, 0);
        chk("rst_state", state, 0);
        chk("rst_instret", instret, 0);
        chk("rst_pcwe", pcwe, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_imem_req", imem_req, 1);
        chk("rel_state", state, 0);
        chk("rel_irwe", irwe, 1);

        // nop: F D
        cyc(1, 0);
        chk("nop_d_state", state, 1);
        chk("nop_d_pcwe", pcwe, 1);
        chk("nop_d_done", instr_done, 1);
        chk("nop_d_npcop", npcop, 0);
        instr = 32'h0022_1821;
        cyc(1, 0);
        chk("nop_instret", instret, 1);
        chk("addu_f_state", state, 0);
        chk("addu_f_wrsel", wrsel, 0);

        // addu $3,$1,$2: F D E W
        cyc(1, 0);
        chk("addu_d_state", state, 1);
        chk("addu_d_pcwe", pcwe, 0);
        chk("addu_d_wrsel", wrsel, 1);
        cyc(1, 0);
        chk("addu_e_state", state, 2);
        chk("addu_e_pcwe", pcwe, 0);
        chk("addu_e_rfwe", rfwe, 0);
        cyc(1, 0);
        chk("addu_w_state", state, 4);
        chk("addu_w_rfwe", rfwe, 1);
        chk("addu_w_wrsel", wrsel, 1);
        chk("addu_w_aluop", aluop, 0);
        chk("addu_w_pcwe", pcwe, 1);
        instr = 32'h8C43_0004;
        cyc(1, 0);
        chk("addu_instret", instret, 2);
        chk("lw_f_rfwe", rfwe, 0);
        chk("lw_f_state", state, 0);

        // lw with two dmem wait cycles: F D E M M M W
        cyc(1, 0);
        chk("lw_d_state", state, 1);
        instr = 32'hA443_0002;   // next word on the bus; must not disturb IR
        cyc(1, 0);
        chk("lw_e_state", state, 2);
        cyc(1, 0);
        chk("lw_m1_state", state, 3);
        chk("lw_m1_req", dmem_req, 1);
        chk("lw_m1_dmwe", dmwe, 0);
        cyc(1, 0);
        chk("lw_m2_state", state, 3);
        chk("lw_m2_req", dmem_req, 1);
        cyc(1, 1);
        chk("lw_m3_state", state, 3);
        chk("lw_m3_dmwe", dmwe, 0);
        chk("lw_m3_pcwe", pcwe, 0);
        cyc(1, 0);
        chk("lw_w_state", state, 4);
        chk("lw_w_wdsel", wdsel, 1);
        chk("lw_w_extop", extop, 1);
        chk("lw_w_rfwe", rfwe, 1);
        chk("lw_w_pcwe", pcwe, 1);
        cyc(1, 0);
        chk("lw_instret", instret, 3);

        // sh with immediate ack (dmem_ack already high in EXE is ignored there)
        cyc(1, 0);
        chk("sh_d_state", state, 1);
        cyc(1, 1);
        chk("sh_e_state", state, 2);
        chk("sh_e_dmwe", dmwe, 0);
        chk("sh_e_pcwe", pcwe, 0);
        cyc(1, 1);
        chk("sh_m_state", state, 3);
        chk("sh_m_dmwe", dmwe, 1);
        chk("sh_m_dmtype", dmtype, 1);
        chk("sh_m_pcwe", pcwe, 1);
        chk("sh_m_rfwe", rfwe, 0);
        instr = 32'h0C00_0010;
        cyc(1, 0);
        chk("sh_next_state", state, 0);
        chk("sh_next_dmwe", dmwe, 0);
        chk("sh_instret", instret, 4);

        // jal: F D W
        cyc(1, 0);
        chk("jal_d_state", state, 1);
        chk("jal_d_pcwe", pcwe, 0);
        cyc(1, 0);
        chk("jal_w_state", state, 4);
        chk("jal_w_wrsel", wrsel, 2);
        chk("jal_w_wdsel", wdsel, 2);
        chk("jal_w_npcop", npcop, 2);
        chk("jal_w_pcwe", pcwe, 1);
        instr = 32'h0800_0010;
        // j with one imem wait cycle
        cyc(0, 0);
        chk("jal_instret", instret, 5);
        chk("j_f1_state", state, 0);
        chk("j_f1_irwe", irwe, 0);
        chk("j_f1_req", imem_req, 1);
        cyc(1, 0);
        chk("j_f2_state", state, 0);
        chk("j_f2_irwe", irwe, 1);
        cyc(1, 0);
        chk("j_d_state", state, 1);
        chk("j_d_pcwe", pcwe, 1);
        chk("j_d_npcop", npcop, 2);
        chk("j_d_rfwe", rfwe, 0);
        instr = 32'h1022_0003;
        cyc(1, 0);
        chk("j_instret", instret, 6);

        // beq: F D E
        cyc(1, 0);
        chk("beq_d_pcwe", pcwe, 0);
        cyc(1, 0);
        chk("beq_e_state", state, 2);
        chk("beq_e_pcwe", pcwe, 1);
        chk("beq_e_npcop", npcop, 1);
        instr = 32'hFC00_0000;
        cyc(1, 0);
        chk("beq_instret", instret, 7);

        // illegal opcode 0x3F: F D as nop
        cyc(1, 0);
        chk("ill_d_state", state, 1);
        chk("ill_d_illegal", illegal, 1);
        chk("ill_d_pcwe", pcwe, 1);
        chk("ill_d_npcop", npcop, 0);
        instr = 32'h8C43_0004;
        cyc(1, 0);
        chk("ill_f_illegal", illegal, 0);
        chk("ill_instret", instret, 8);

        // lw aborted by reset in MEM
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        chk("abort_m_state", state, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_state", state, 0);
        chk("abort_rfwe", rfwe, 0);
        chk("abort_pcwe", pcwe, 0);
        chk("abort_imem_req", imem_req, 0);
        chk("abort_instret", instret, 0);
        @(posedge clk);
        #1;
        chk("abort_hold_rfwe", rfwe, 0);
        instr   = 32'h0000_0000;
        reset_n = 1'b1;
        #1;
        chk("abort_rel_state", state, 0);
        chk("abort_rel_req", imem_req, 1);
        cyc(1, 0);
        chk("post_nop_pcwe", pcwe, 1);
        cyc(1, 0);
        chk("post_nop_instret", instret, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle decoder and drives the existing PC, IR, GRF, ALU, EXT and DM muxes with the same control encodings, stepping each instruction through FETCH/DECODE/EXE/MEM/WB. Instruction and data memory accesses use a req/ack handshake, so either memory may insert wait states. The block also counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction word from IM; sampled only in FETCH when imem_ack=1
- imem_ack  in  1  IM has valid data this cycle
- dmem_ack  in  1  DM completes the access this cycle
- imem_req  out  1  fetch request; high throughout FETCH (0 while reset_n=0)
- irwe  out  1  IR load strobe; equals imem_ack in FETCH
- pcwe  out  1  PC write strobe; one pulse per instruction, in its last cycle
- rfwe  out  1  GRF write strobe; WB only
- dmem_req  out  1  DM request; high throughout MEM
- dmwe  out  1  DM write; equals dmem_req for sw/sh
- npcop  out  5  0 PC+4, 1 beq, 2 j/jal, 3 jr/jalr, 4 bgtz
- wrsel  out  2  0 rt, 1 rd, 2 $31
- wdsel  out  2  0 ALU, 1 DM, 2 PC+4
- extop  out  2  0 zero-extend, 1 sign-extend
- asel  out  2  0 rs, 1 shamt
- bsel  out  2  0 rt, 1 ext(imm)
- aluop  out  5  0 add, 1 sub, 2 or, 3 lui, 4 passA, 5 sll, 6 slt
- dmtype  out  2  0 word, 1 half, 2 byte
- state  out  3  0 FETCH, 1 DECODE, 2 EXE, 3 MEM, 4 WB
- illegal  out  1  high during DECODE of an unrecognised instruction
- instr_done  out  1  equals pcwe
- instret  out  32  retired-instruction count

## Operation
- Internal 32-bit IR loaded on FETCH && imem_ack. Mux fields are decoded from IR and forced to 0 in FETCH. From DECODE to the end of the instruction they hold constant.
- State sequence, where L is the last state:
  - addu, subu, sll, slt, ori, lui: F D E W
  - lw, lb: F D E M W
  - sw, sh: F D E M
  - beq, bgtz, jr: F D E
  - j: F D
  - jal, jalr: F D W
  - IR==0 (nop) and illegal: F D; illegal is handled as nop with npcop=0.
- R-type instructions decode on funct with op==0. All others decode on op.
- In L: pcwe=1 for one cycle, instret+=1 (wraps at 2^32), next state FETCH.
- FETCH stays while imem_ack=0. MEM stays while dmem_ack=0. Leaving MEM happens on the ack cycle; for stores that ack cycle is L.
- rfwe is asserted only in WB, for exactly one cycle. dmwe is never high outside MEM.
- No other state stalls.

## Timing
- Reset (async assert, sync release): state=FETCH, IR=0, instret=0. All strobes and fields are 0, and imem_req=0 while reset_n=0.
- Zero-wait cycle counts: j/nop 2; beq/jr/jal 3; ALU/sw 4; lw 5. Each wait cycle on an ack adds 1.
- Outputs are Moore on state/IR, except irwe (imem_ack), leaving MEM (dmem_ack), and pcwe in MEM for stores.
- Reset mid-instruction aborts it immediately: no pcwe, no rfwe, no instret increment. Restart is from FETCH.
- An ack asserted outside its state is ignored.

## Test plan
- Reset with imem_ack=1 held → after release: imem_req=1, state=0. The first fetch of 0x00000000 (nop) gives pcwe in cycle 2 and instret=1.
- addu $3,$1,$2 (0x00221821), zero-wait → states 0,1,2,4. In WB: rfwe=1, wrsel=1, aluop=0. pcwe only in cycle 4.
- lw (0x8C430004) with dmem_ack delayed 2 cycles → MEM lasts 3 cycles with dmem_req=1 and dmwe=0. WB has wdsel=1, extop=1. Total 7 cycles.
- sh (0xA4430002) with immediate dmem_ack → dmwe=1 for 1 cycle, dmtype=1, pcwe in the same cycle, rfwe never set.
- jal (0x0C000010) → 3 cycles; WB has wrsel=2, wdsel=2, npcop=2. Then j (0x08000010) takes 2 cycles with rfwe=0.
- Opcode 0x3F → illegal=1 in DECODE, pcwe with npcop=0, instret increments. Separately, assert reset_n=0 mid-MEM of lw → no rfwe, instret unchanged, FETCH after release.
